// File: rtl/fb_arb_pkg.sv
// Shared definitions for the framebuffer port arbiter: default sizes, grant and clear-state encodings.
package fb_arb_pkg;

  localparam int unsigned DEF_ADDR_W   = 15;
  localparam int unsigned DEF_DATA_W   = 12;
  localparam int unsigned DEF_FB_DEPTH = 19200;
  localparam logic [11:0] DEF_CLR_COLOR = 12'h000;
  localparam int unsigned STALL_W      = 16;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_DISP,
    GNT_CLR,
    GNT_WR
  } gnt_e;

  typedef enum logic {
    CLR_IDLE,
    CLR_RUN
  } clr_state_e;

endpackage

// File: rtl/fb_clear_seq.sv
// Clear sequencer: walks the framebuffer address range once per start pulse,
// stepping only on cycles where the arbiter lets the clear write through.
module fb_clear_seq
  import fb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned FB_DEPTH = DEF_FB_DEPTH
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              start,
  input  logic              advance,
  output logic              busy,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  clr_state_e state;

  // Final word of the sweep is being presented.
  assign last = (state == CLR_RUN) && (addr == LAST_ADDR);

  // Clear FSM with address counter; start while running is ignored.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state <= CLR_IDLE;
      busy  <= 1'b0;
      addr  <= '0;
    end else begin
      case (state)
        CLR_IDLE: begin
          if (start) begin
            state <= CLR_RUN;
            busy  <= 1'b1;
            addr  <= '0;
          end
        end
        CLR_RUN: begin
          if (advance) begin
            if (last) begin
              state <= CLR_IDLE;
              busy  <= 1'b0;
              addr  <= '0;
            end else begin
              addr <= addr + ADDR_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer BRAM arbiter: display reads > clear engine > drawing writer.
// Build option FB_ARB_CLEAR_EN adds the hardware clear engine; without it clr_busy is 0.
module fb_port_arbiter
  import fb_arb_pkg::*;
#(
  parameter int unsigned        ADDR_W    = DEF_ADDR_W,
  parameter int unsigned        DATA_W    = DEF_DATA_W,
  parameter int unsigned        FB_DEPTH  = DEF_FB_DEPTH,
  parameter logic [DATA_W-1:0]  CLR_COLOR = DATA_W'(DEF_CLR_COLOR)
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               disp_req,
  input  logic [ADDR_W-1:0]  disp_addr,
  output logic [DATA_W-1:0]  disp_data,
  output logic               disp_data_valid,
  input  logic               wr_valid,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  output logic               wr_ready,
  input  logic               clr_start,
  output logic               clr_busy,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic [STALL_W-1:0] stall_cnt
);

  gnt_e              gnt;
  logic [ADDR_W-1:0] clr_addr;
  logic              rd_pend;

`ifdef FB_ARB_CLEAR_EN
  logic clr_last_unused;

  fb_clear_seq #(
    .ADDR_W   (ADDR_W),
    .FB_DEPTH (FB_DEPTH)
  ) u_clear_seq (
    .clk_in  (clk_in),
    .reset   (reset),
    .start   (clr_start),
    .advance (gnt == GNT_CLR),
    .busy    (clr_busy),
    .addr    (clr_addr),
    .last    (clr_last_unused)
  );
`else
  logic unused_clr_cfg;

  assign clr_busy       = 1'b0;
  assign clr_addr       = '0;
  assign unused_clr_cfg = ^{clr_start, 1'(FB_DEPTH)};
`endif

  assign wr_ready = !disp_req && !clr_busy;

  // Fixed-priority grant for the current cycle.
  always_comb begin
    gnt = GNT_NONE;
    if (disp_req) begin
      gnt = GNT_DISP;
    end else if (clr_busy) begin
      gnt = GNT_CLR;
    end else if (wr_valid) begin
      gnt = GNT_WR;
    end
  end

  // BRAM port mux driven straight from the grant; idle port drives zeros.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (gnt)
      GNT_DISP: begin
        mem_en   = 1'b1;
        mem_addr = disp_addr;
      end
      GNT_CLR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = clr_addr;
        mem_wdata = CLR_COLOR;
      end
      GNT_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
      end
      default: ;
    endcase
  end

  // Read pipeline: BRAM data arrives one cycle after the read, registered one more.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      rd_pend         <= 1'b0;
      disp_data_valid <= 1'b0;
      disp_data       <= '0;
    end else begin
      rd_pend         <= (gnt == GNT_DISP);
      disp_data_valid <= rd_pend;
      if (rd_pend) begin
        disp_data <= mem_rdata;
      end
    end
  end

  // Saturating count of cycles the writer waited.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (wr_valid && !wr_ready && (stall_cnt != {STALL_W{1'b1}})) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Randomized and directed bench for fb_port_arbiter against a cycle-level reference model.
module tb_fb_port_arbiter;

  localparam int DEPTH = 8;
`ifdef FB_ARB_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        reset;
  logic        disp_req;
  logic [14:0] disp_addr;
  logic [11:0] disp_data;
  logic        disp_data_valid;
  logic        wr_valid;
  logic [14:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_ready;
  logic        clr_start;
  logic        clr_busy;
  logic        mem_en;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic [15:0] stall_cnt;

  fb_port_arbiter #(
    .ADDR_W    (15),
    .DATA_W    (12),
    .FB_DEPTH  (DEPTH),
    .CLR_COLOR (12'h000)
  ) dut (
    .clk_in          (clk_in),
    .reset           (reset),
    .disp_req        (disp_req),
    .disp_addr       (disp_addr),
    .disp_data       (disp_data),
    .disp_data_valid (disp_data_valid),
    .wr_valid        (wr_valid),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .wr_ready        (wr_ready),
    .clr_start       (clr_start),
    .clr_busy        (clr_busy),
    .mem_en          (mem_en),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .stall_cnt       (stall_cnt)
  );

  always #5 clk_in = ~clk_in;

  // Simple 1-cycle-latency BRAM.
  logic [11:0] bram [0:32767];
  always @(posedge clk_in) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= bram[mem_addr];
    end
  end

  // Reference model state.
  typedef struct {
    int          due;
    logic [11:0] data;
  } rd_t;

  logic [11:0] shadow [0:32767];
  rd_t         rq[$];
  bit          m_busy;
  int          m_caddr;
  int          m_stall;
  bit          m_dv;
  logic [11:0] m_dd;
  int          cyc;
  int          n_checks;
  int          n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Compare this cycle's outputs, advance the model, move to the next cycle.
  task automatic tick();
    bit          e_en;
    bit          e_we;
    logic [14:0] e_addr;
    logic [11:0] e_wd;
    bit          e_rdy;
    #1;
    e_rdy  = !disp_req && !m_busy;
    e_en   = 1'b0;
    e_we   = 1'b0;
    e_addr = '0;
    e_wd   = '0;
    if (disp_req) begin
      e_en = 1'b1; e_addr = disp_addr;
    end else if (m_busy) begin
      e_en = 1'b1; e_we = 1'b1; e_addr = 15'(m_caddr); e_wd = 12'h000;
    end else if (wr_valid) begin
      e_en = 1'b1; e_we = 1'b1; e_addr = wr_addr; e_wd = wr_data;
    end
    if (!reset) begin
      check("mem_en",    32'(mem_en),          32'(e_en));
      check("mem_we",    32'(mem_we),          32'(e_we));
      check("mem_addr",  32'(mem_addr),        32'(e_addr));
      check("mem_wdata", 32'(mem_wdata),       32'(e_wd));
      check("wr_ready",  32'(wr_ready),        32'(e_rdy));
      check("disp_dv",   32'(disp_data_valid), 32'(m_dv));
      check("disp_data", 32'(disp_data),       32'(m_dd));
      check("clr_busy",  32'(clr_busy),        32'(m_busy));
      check("stall_cnt", 32'(stall_cnt),       32'(m_stall));
    end
    m_dv = 1'b0;
    if (rq.size() > 0 && rq[0].due == cyc + 1) begin
      m_dv = 1'b1;
      m_dd = rq[0].data;
      void'(rq.pop_front());
    end
    if (disp_req) rq.push_back('{cyc + 2, shadow[disp_addr]});
    if (e_we) shadow[e_addr] = e_wd;
    if (m_busy) begin
      if (!disp_req) begin
        if (m_caddr == DEPTH - 1) begin
          m_busy = 1'b0; m_caddr = 0;
        end else begin
          m_caddr++;
        end
      end
    end else if (CLR_EN && clr_start) begin
      m_busy = 1'b1; m_caddr = 0;
    end
    if (wr_valid && !e_rdy && m_stall < 65535) m_stall++;
    if (reset) begin
      m_busy = 1'b0; m_caddr = 0; m_stall = 0; m_dv = 1'b0; m_dd = '0;
      rq.delete();
    end
    cyc++;
    @(negedge clk_in);
  endtask

  task automatic idle_inputs();
    reset = 1'b0; disp_req = 1'b0; disp_addr = '0; wr_valid = 1'b0;
    wr_addr = '0; wr_data = '0; clr_start = 1'b0;
  endtask

  task automatic rand_inputs();
    reset     = ($urandom_range(0, 399) == 0);
    disp_req  = !reset && ($urandom_range(0, 9) < 4);
    disp_addr = ($urandom_range(0, 7) == 0) ? 15'($urandom) : 15'($urandom_range(0, 15));
    wr_valid  = !reset && ($urandom_range(0, 1) == 1);
    wr_addr   = ($urandom_range(0, 7) == 0) ? 15'($urandom) : 15'($urandom_range(0, 15));
    wr_data   = 12'($urandom);
    clr_start = !reset && ($urandom_range(0, 49) == 0);
  endtask

  initial begin
    int busy_len;
    n_checks = 0; n_errors = 0; cyc = 0;
    m_busy = 1'b0; m_caddr = 0; m_stall = 0; m_dv = 1'b0; m_dd = '0;
    idle_inputs();

    // Reset for 3 cycles, then idle.
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_dv",    32'(disp_data_valid), 32'd0);
    check("rst_stall", 32'(stall_cnt),       32'd0);
    tick();

    // Write 12'hF0A to 0x0010, then read it back.
    wr_valid = 1'b1; wr_addr = 15'h0010; wr_data = 12'hF0A;
    tick();
    idle_inputs();
    disp_req = 1'b1; disp_addr = 15'h0010;
    tick();
    idle_inputs();
    check("rd_n1_dv", 32'(disp_data_valid), 32'd0);
    tick();
    check("rd_n2_dv",   32'(disp_data_valid), 32'd1);
    check("rd_n2_data", 32'(disp_data),       32'h0F0A);
    tick();
    check("rd_n3_dv", 32'(disp_data_valid), 32'd0);

    // Display blocks the writer for one cycle.
    disp_req = 1'b1; disp_addr = 15'h0002;
    wr_valid = 1'b1; wr_addr = 15'd5; wr_data = 12'h123;
    tick();
    disp_req = 1'b0;
    tick();
    idle_inputs();
    check("stall_one", 32'(stall_cnt), 32'd1);
    repeat (3) tick();

    // Uninterrupted clear.
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    busy_len = 0;
    for (int i = 0; i < 12; i++) begin
      if (clr_busy) busy_len++;
      tick();
    end
    check("clr_len", 32'(busy_len), CLR_EN ? 32'd8 : 32'd0);

    // Clear interleaved with display reads, writer waiting throughout.
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    wr_valid = 1'b1; wr_addr = 15'd9; wr_data = 12'hABC;
    for (int i = 0; i < 20; i++) begin
      disp_req  = (i % 2 == 0);
      disp_addr = 15'(i);
      tick();
    end
    idle_inputs();
    repeat (3) tick();

    // Reset part way through a clear, then restart.
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_busy", 32'(clr_busy), 32'd0);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (10) tick();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      tick();
    end
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // Long writer stall saturates the counter.
    disp_req = 1'b1; disp_addr = 15'd1; wr_valid = 1'b1; wr_addr = 15'd3; wr_data = 12'h555;
    repeat (70000) tick();
    check("stall_sat", 32'(stall_cnt), 32'h0000FFFF);
    idle_inputs();
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
